// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared types and constants for the sequential adder/subtractor.
//               state_t - controller states (IDLE, CALC, DONE)
//               OP_ADD / OP_SUB - encodings of the sel input
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
// Module      : addsub_slice
// Description : Combinational CHUNK-bit ripple adder used once per cycle by
//               the sequential adder/subtractor.
//   Ports     : a, b  [CHUNK-1:0] slice operands
//               cin               carry in
//               s     [CHUNK-1:0] slice sum
//               cout              carry out of the slice MSB
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] w_sum;

    always_comb begin
        w_sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        s     = w_sum[CHUNK-1:0];
        cout  = w_sum[CHUNK];
    end

endmodule : addsub_slice
`default_nettype wire

// File: rtl/seq_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : seq_adder_subtractor
// Description : Multi-cycle two's-complement adder/subtractor. WIDTH-bit
//               operands are processed CHUNK bits per clock through a single
//               slice adder with a registered carry between slices.
//   Ports     : clk, rst (sync, active high)
//               in_valid / in_ready   operand handshake (a, b, sel)
//               sel                   0 = A+B, 1 = A-B (A + ~B + 1)
//               out_valid / out_ready result handshake
//               result, carry_out, overflow, zero, negative (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_adder_subtractor
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int MSB   = WIDTH - 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

    // Reject configurations whose width is not a whole number of slices.
    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_width
            $fatal(1, "seq_adder_subtractor: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b_eff;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_next;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;
    logic               r_negative;
    logic [CHUNK-1:0]   w_slice_a;
    logic [CHUNK-1:0]   w_slice_b;
    logic [CHUNK-1:0]   w_slice_s;
    logic               w_slice_c;
    logic               w_last;
    logic               w_res_msb;

    // Select the current slice of the captured operands.
    always_comb begin
        w_slice_a = r_a[r_cnt*CHUNK +: CHUNK];
        w_slice_b = r_b_eff[r_cnt*CHUNK +: CHUNK];
    end

    addsub_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (w_slice_a),
        .b    (w_slice_b),
        .cin  (r_carry),
        .s    (w_slice_s),
        .cout (w_slice_c)
    );

    // Result with the current slice merged in; the flags on the final slice
    // must see the complete word, including the slice written this cycle.
    always_comb begin
        w_result_next = r_result;
        w_result_next[r_cnt*CHUNK +: CHUNK] = w_slice_s;
        w_res_msb = w_result_next[MSB];
        w_last    = (r_state == CALC) && (r_cnt == C_LAST);
    end

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = CALC;
            CALC:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b_eff     <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B here and seed
                        // the carry chain with the +1.
                        r_a     <= a;
                        r_b_eff <= b ^ {WIDTH{sel == OP_SUB}};
                        r_carry <= (sel == OP_SUB);
                        r_cnt   <= '0;
                    end
                end
                CALC: begin
                    r_result <= w_result_next;
                    r_carry  <= w_slice_c;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_carry_out <= w_slice_c;
                        r_overflow  <= (r_a[MSB] == r_b_eff[MSB]) && (w_res_msb != r_a[MSB]);
                        r_zero      <= (w_result_next == '0);
                        r_negative  <= w_res_msb;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        result    = r_result;
        carry_out = r_carry_out;
        overflow  = r_overflow;
        zero      = r_zero;
        negative  = r_negative;
    end

endmodule : seq_adder_subtractor
`default_nettype wire

// File: tb/tb_seq_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_adder_subtractor
// Description : Self-checking bench for seq_adder_subtractor (WIDTH=32,
//               CHUNK=8) against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_adder_subtractor;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    seq_adder_subtractor #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, then read off the flags.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t   m;
        longint ideal;
        longint ux;
        longint uy;
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        if (s) begin
            ideal = longint'($signed(x)) - longint'($signed(y));
            m.r   = x - y;
            m.c   = (ux >= uy);
        end else begin
            ideal = longint'($signed(x)) + longint'($signed(y));
            m.r   = x + y;
            m.c   = ((ux + uy) > 64'sd4294967295);
        end
        m.v = (ideal > 64'sd2147483647) || (ideal < -64'sd2147483648);
        m.z = (m.r == 32'd0);
        m.n = m.r[31];
        return m;
    endfunction

    // Stimulus helpers (no checking). All start and end #1 after a rising edge.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        a        = x;
        b        = y;
        sel      = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        sel      = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc <= 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sel       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_handshake: in_ready/out_valid=%b required 10", {in_ready, out_valid});
        end
        checks++;
        if ({result, carry_out, overflow, zero, negative} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs: result=%h flags=%b required 0/0000",
                     result, {carry_out, overflow, zero, negative});
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [5] = '{32'h0000_00FF, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] tb [5] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1234_5678};
        logic        ts [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_t        m;
        int          cyc;
        for (int i = 0; i < 5; i++) begin
            m = model(ta[i], tb[i], ts[i]);
            start_op(ta[i], tb[i], ts[i]);
            wait_done(cyc);
            checks++;
            if (cyc !== N) begin
                failures++;
                $display("FAIL directed%0d_latency: cycles=%0d required %0d", i, cyc, N);
            end
            checks++;
            if (result !== m.r) begin
                failures++;
                $display("FAIL directed%0d_result: result=%h required %h", i, result, m.r);
            end
            checks++;
            if ({carry_out, overflow, zero, negative} !== {m.c, m.v, m.z, m.n}) begin
                failures++;
                $display("FAIL directed%0d_flags: cvzn=%b required %b", i,
                         {carry_out, overflow, zero, negative}, {m.c, m.v, m.z, m.n});
            end
            release_result();
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                failures++;
                $display("FAIL directed%0d_release: in_ready/out_valid=%b required 10", i, {in_ready, out_valid});
            end
        end
        // Literal check of the first scenario, independent of the model.
        start_op(32'h0000_00FF, 32'h1, 1'b0);
        wait_done(cyc);
        checks++;
        if ({result, carry_out, overflow, zero, negative} !== {32'h0000_0100, 4'b0000}) begin
            failures++;
            $display("FAIL literal_carry_chain: result=%h cvzn=%b required 00000100/0000",
                     result, {carry_out, overflow, zero, negative});
        end
        release_result();
    endtask

    task automatic test_backpressure();
        exp_t m;
        int   cyc;
        m = model(32'h8000_0000, 32'h1, 1'b1);
        start_op(32'h8000_0000, 32'h1, 1'b1);
        wait_done(cyc);
        // Offer a competing operation while the result is stalled.
        a        = 32'h0000_0005;
        b        = 32'h0000_0007;
        sel      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, result, carry_out, overflow, zero, negative}
                !== {2'b10, m.r, m.c, m.v, m.z, m.n}) begin
                failures++;
                $display("FAIL stall%0d: ov/ir=%b result=%h cvzn=%b required 10/%h/%b", i,
                         {out_valid, in_ready}, result, {carry_out, overflow, zero, negative},
                         m.r, {m.c, m.v, m.z, m.n});
            end
        end
        in_valid = 1'b0;
        release_result();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL stall_release: in_ready/out_valid=%b required 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int stale;
        start_op(32'hDEAD_BEEF, 32'h0102_0304, 1'b0);   // E0 accepted
        @(posedge clk);                                 // E1: first CALC edge
        #1;
        rst = 1'b1;                                     // sampled at E2
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, result, carry_out, overflow, zero, negative} !== {2'b10, 36'd0}) begin
            failures++;
            $display("FAIL midreset_state: ir/ov=%b result=%h cvzn=%b required 10/0/0000",
                     {in_ready, out_valid}, result, {carry_out, overflow, zero, negative});
        end
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL midreset_stale: out_valid cycles=%0d required 0", stale);
        end
        start_op(32'd5, 32'd3, 1'b0);
        wait_done(cyc);
        checks++;
        if (result !== 32'd8 || cyc !== N) begin
            failures++;
            $display("FAIL midreset_followup: result=%0d cycles=%0d required 8/%0d", result, cyc, N);
        end
        release_result();
    endtask

    task automatic test_random();
        exp_t        m;
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        int          cyc;
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            y = $urandom;
            s = 1'($urandom);
            if (i % 8 == 0) y = x;                  // exercise zero / equal operands
            if (i % 8 == 1) y = ~x;                 // exercise all-ones sums
            m = model(x, y, s);
            start_op(x, y, s);
            wait_done(cyc);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if ({out_valid, result, carry_out, overflow, zero, negative}
                !== {1'b1, m.r, m.c, m.v, m.z, m.n}) begin
                failures++;
                $display("FAIL random%0d: a=%h b=%h sel=%b ov=%b result=%h cvzn=%b required %h/%b",
                         i, x, y, s, out_valid, result, {carry_out, overflow, zero, negative},
                         m.r, {m.c, m.v, m.z, m.n});
            end
            release_result();
        end
    endtask

    task automatic test_back_to_back();
        exp_t expq[$];
        exp_t m;
        int   cycle;
        int   last_accept;
        int   accepts;
        int   seen;
        logic r_rdy;
        logic v_out;
        cycle       = 0;
        last_accept = -1;
        accepts     = 0;
        seen        = 0;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        a           = $urandom;
        b           = $urandom;
        sel         = 1'($urandom);
        while ((accepts < 5 || expq.size() > 0) && cycle < 200) begin
            r_rdy = in_ready;
            v_out = out_valid;
            if (v_out) begin
                seen++;
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected: out_valid with no pending op");
                end else begin
                    m = expq.pop_front();
                    if ({result, carry_out, overflow, zero, negative} !== {m.r, m.c, m.v, m.z, m.n}) begin
                        failures++;
                        $display("FAIL b2b_result: result=%h cvzn=%b required %h/%b",
                                 result, {carry_out, overflow, zero, negative}, m.r, {m.c, m.v, m.z, m.n});
                    end
                end
            end
            if (r_rdy && in_valid) expq.push_back(model(a, b, sel));
            @(posedge clk);
            cycle++;
            #1;
            if (r_rdy && in_valid) begin
                accepts++;
                if (last_accept >= 0) begin
                    checks++;
                    if (cycle - last_accept !== N + 2) begin
                        failures++;
                        $display("FAIL b2b_spacing: cycles=%0d required %0d", cycle - last_accept, N + 2);
                    end
                end
                last_accept = cycle;
                a   = $urandom;
                b   = $urandom;
                sel = 1'($urandom);
                if (accepts >= 5) in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (seen !== 5) begin
            failures++;
            $display("FAIL b2b_count: results=%0d required 5", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_adder_subtractor
`default_nettype wire
